serial_adder_ctrl: RTL

Bit-serial adder datapath and controller that feeds the team's 1-bit adder cell one operand bit pair per clock.
- Accepts two WIDTH-bit operands on a start pulse and shifts them out LSB-first.
- Combines each bit pair with a registered carry and collects the sum bits into a result register.
- Presents the WIDTH-bit sum plus carry-out with a one-cycle done pulse.
- Sits between the lab's parallel operand source (switches or registers) and the gate-level adder stage, reusing a single adder cell over WIDTH cycles.

---
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder datapath and controller.
// Captures two WIDTH-bit operands on start and feeds one bit pair per clock,
// LSB first, through a single full-adder cell with a registered carry.
// Sum and carry-out are published together with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement
// subtraction (B inverted, carry-in forced to 1, cout=1 means no borrow).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             s_bit;
    logic             c_nxt;

    // Operand/carry values loaded on an accepted start (subtract inverts B, forces carry 1)
    always_comb begin
        b_load = b_in;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b_in;
            c_load = 1'b1;
        end
`endif
    end

    // Next-state and datapath: one full-adder step per ADD cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        s_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        c_nxt   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                carry_d = c_nxt;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the completed word so sum never shows partials
                if (cnt_q == LAST) begin
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
